simd_controller: RTL and testbench
==================================

// Module: simd_controller
// PURPOSE
//  Sequencer for one SIMD unit. Fetch/decode/execute FSM that walks one wavefront through the shared
//  16-lane datapath (RegisterFile, LSU, PC, Fetcher), one wave cycle per pass.
//  Drives simd_state, curr_wave_cycle, the per-lane active mask, datapath control strobes and simd_done.
// PARAMETERS
//  INSTRUCTION_WIDTH  32   instruction word width
//  LANE_WIDTH         16   lanes per SIMD
//  WAVE_SIZE          32   threads per wavefront
//  TIMEOUT_CYCLES     256  max WAIT cycles (only with SIMD_WAIT_TIMEOUT_EN)
//  Derived: TOTAL_WAVE_CYCLES=ceil(WAVE_SIZE/LANE_WIDTH); CW=max(1,$clog2(TOTAL_WAVE_CYCLES))
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous reset, active-low
//  enable           in   1     low: all state and outputs frozen
//  simd_start       in   1     dispatch pulse, accepted in IDLE or DONE
//  num_threads      in   32    kernel total threads
//  block_dim        in   32    threads per block
//  block_id         in   32    block index (treated as unsigned)
//  wave_id          in   32    wave index within block
//  instr_valid      in   1     Fetcher holds a valid instruction
//  instruction      in   IW    fetched instruction; opcode=[IW-1:IW-4]
//  lsu_done         in   LW    per-lane LSU completed current request
//  simd_state       out  3     FSM state code
//  curr_wave_cycle  out  CW    wave cycle being executed
//  lane_active      out  LW    lanes holding a valid thread this wave cycle
//  REG_WRITE        out  1     RF write enable
//  MEM_READ         out  1     LSU load
//  MEM_WRITE        out  1     LSU store
//  MEM_TO_REG       out  1     RF write source: 1 = LSU, 0 = ALU
//  pc_advance       out  1     1-cycle pulse: PC increments
//  simd_done        out  1     wavefront retired
//  wait_timeout     out  1     sticky WAIT-timeout flag (macro only)
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7.
//  Reset (rst=0, asynchronous): state IDLE, cycle 0, every output 0. Applies from any state, including mid-WAIT.
//  IDLE / DONE:
//   - simd_start -> FETCH, cycle=0, simd_done=0.
//   - simd_start in any other state is ignored.
//  FETCH: stay until instr_valid=1, then latch instruction -> DECODE.
//  DECODE (one cycle). Opcode sets control, latched until the instruction retires:
//   - 4'b0000 NOP: no strobes
//   - 4'b1000 LDR: MEM_READ, REG_WRITE, MEM_TO_REG
//   - 4'b1001 STR: MEM_WRITE
//   - 4'b1111 RET: -> DONE, no datapath pass
//   - others (ALU): REG_WRITE
//  Non-RET -> REQUEST.
//  REQUEST: one cycle -> WAIT.
//  WAIT:
//   - Non-memory op: exit after exactly 1 cycle.
//   - Memory op: exit when &(lsu_done | ~lane_active) == 1. Exit -> EXECUTE.
//  EXECUTE: one cycle -> UPDATE.
//  UPDATE:
//   - cycle < TOTAL_WAVE_CYCLES-1: cycle+1 -> REQUEST.
//   - Else: cycle=0, pc_advance=1 for this cycle, control strobes cleared -> FETCH.
//  Latency: non-memory instruction = 1 DECODE + 4*TOTAL_WAVE_CYCLES cycles (9 at defaults) from DECODE entry to FETCH.
//  lane_active[i], combinational from registered cycle and inputs, 32-bit unsigned, wrap not handled:
//   - local  = wave_id*WAVE_SIZE + cycle*LANE_WIDTH + i
//   - global = block_id*block_dim + local
//   - active = (local < block_dim) && (global < num_threads)
//  All-zero mask: the pass still runs the full sequence; memory WAIT exits after 1 cycle.
//  simd_done: 1 from the cycle after entering DONE until the next accepted simd_start.
//  enable=0 takes priority over all transitions; the async reset still acts.
// CONFIGURATION
//  SIMD_WAIT_TIMEOUT_EN defined:
//   - A counter runs in memory WAIT.
//   - After TIMEOUT_CYCLES cycles -> DONE and wait_timeout=1; flag held until reset or simd_start.
//  Not defined:
//   - WAIT is unbounded.
//   - wait_timeout is tied to 0 and the counter is not present.
// TESTING
//  1 ADD (4'b0001), block_dim=32, num_threads=64, ids=0 -> REG_WRITE=1; lane_active=16'hFFFF in cycles 0 and 1; pc_advance pulses 9 clks after DECODE entry.
//  2 LDR; lsu_done[5] rises 3 clks after the other lanes -> stays WAIT until lane 5; MEM_READ/MEM_TO_REG=1 throughout.
//  3 block_dim=20, wave_id=0 -> mask 16'hFFFF in cycle 0, 16'h000F in cycle 1; lsu_done[3:0] alone releases cycle-1 WAIT.
//  4 RET -> DONE, simd_done=1 and held. New simd_start -> FETCH, simd_done=0, curr_wave_cycle=0.
//  5 rst low mid-WAIT -> state 0 and all outputs 0 without a clock edge. enable=0 in REQUEST for 5 clks -> state frozen.
//  6 Macro on, TIMEOUT_CYCLES=8, STR with lsu_done=0 -> DONE after 8 WAIT clks, wait_timeout=1. Macro off -> remains in WAIT.

Source files
------------

// File: rtl/simd_controller_if.sv
// Handshake and datapath-control bundle between a SIMD dispatcher/datapath (master) and simd_controller (slave).
interface simd_controller_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LANE_WIDTH        = 16,
  parameter int WAVE_SIZE         = 32
);
  localparam int TOTAL_WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int CW = (TOTAL_WAVE_CYCLES > 1) ? $clog2(TOTAL_WAVE_CYCLES) : 1;

  logic                         enable;
  logic                         simd_start;
  logic [31:0]                  num_threads;
  logic [31:0]                  block_dim;
  logic [31:0]                  block_id;
  logic [31:0]                  wave_id;
  logic                         instr_valid;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [LANE_WIDTH-1:0]        lsu_done;

  logic [2:0]                   simd_state;
  logic [CW-1:0]                curr_wave_cycle;
  logic [LANE_WIDTH-1:0]        lane_active;
  logic                         REG_WRITE;
  logic                         MEM_READ;
  logic                         MEM_WRITE;
  logic                         MEM_TO_REG;
  logic                         pc_advance;
  logic                         simd_done;
  logic                         wait_timeout;

  modport master (
    output enable, simd_start, num_threads, block_dim, block_id, wave_id,
           instr_valid, instruction, lsu_done,
    input  simd_state, curr_wave_cycle, lane_active, REG_WRITE, MEM_READ,
           MEM_WRITE, MEM_TO_REG, pc_advance, simd_done, wait_timeout
  );

  modport slave (
    input  enable, simd_start, num_threads, block_dim, block_id, wave_id,
           instr_valid, instruction, lsu_done,
    output simd_state, curr_wave_cycle, lane_active, REG_WRITE, MEM_READ,
           MEM_WRITE, MEM_TO_REG, pc_advance, simd_done, wait_timeout
  );
endinterface

// File: rtl/simd_controller.sv
// Fetch/decode/execute sequencer walking one wavefront through a shared SIMD datapath.
// Optional WAIT timeout enabled by defining SIMD_WAIT_TIMEOUT_EN.
module simd_controller #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LANE_WIDTH        = 16,
  parameter int WAVE_SIZE         = 32
`ifdef SIMD_WAIT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES  = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  simd_controller_if.slave bus
);
  localparam int TWC = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int CW  = (TWC > 1) ? $clog2(TWC) : 1;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDR = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_RET = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cycle_q, cycle_d;
  logic [3:0]      opcode_q, opcode_d;
  // {REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG}
  logic [3:0]      ctl_q, ctl_d;
  logic            pc_advance_q, pc_advance_d;
  logic            simd_done_q, simd_done_d;

  logic [LANE_WIDTH-1:0] lane_act;
  logic [31:0]           wave_base, blk_base;
  logic                  mem_op, lanes_ready, last_cycle;

`ifdef SIMD_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          wait_timeout_q, wait_timeout_d;
`endif

  assign wave_base = bus.wave_id * 32'(WAVE_SIZE) + 32'(cycle_q) * 32'(LANE_WIDTH);
  assign blk_base  = bus.block_id * bus.block_dim;

  always_comb begin
    lane_act = '0;
    for (int i = 0; i < LANE_WIDTH; i++) begin
      lane_act[i] = ((wave_base + 32'(i)) < bus.block_dim) &&
                    ((blk_base + wave_base + 32'(i)) < bus.num_threads);
    end
  end

  assign mem_op      = ctl_q[2] | ctl_q[1];
  assign lanes_ready = &(bus.lsu_done | ~lane_act);
  assign last_cycle  = (cycle_q == CW'(TWC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cycle_q      <= '0;
      opcode_q     <= '0;
      ctl_q        <= '0;
      pc_advance_q <= 1'b0;
      simd_done_q  <= 1'b0;
`ifdef SIMD_WAIT_TIMEOUT_EN
      to_cnt_q       <= '0;
      wait_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      opcode_q     <= opcode_d;
      ctl_q        <= ctl_d;
      pc_advance_q <= pc_advance_d;
      simd_done_q  <= simd_done_d;
`ifdef SIMD_WAIT_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      wait_timeout_q <= wait_timeout_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    opcode_d     = opcode_q;
    ctl_d        = ctl_q;
    pc_advance_d = pc_advance_q;
    simd_done_d  = simd_done_q;
`ifdef SIMD_WAIT_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    wait_timeout_d = wait_timeout_q;
`endif
    if (bus.enable) begin
      pc_advance_d = 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) simd_done_d = 1'b1;
          if (bus.simd_start) begin
            state_d     = S_FETCH;
            cycle_d     = '0;
            simd_done_d = 1'b0;
`ifdef SIMD_WAIT_TIMEOUT_EN
            wait_timeout_d = 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (bus.instr_valid) begin
            opcode_d = bus.instruction[INSTRUCTION_WIDTH-1 -: 4];
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          ctl_d   = 4'b0000;
          state_d = S_REQUEST;
          case (opcode_q)
            OP_NOP:  ctl_d = 4'b0000;
            OP_LDR:  ctl_d = 4'b1101;
            OP_STR:  ctl_d = 4'b0010;
            OP_RET:  state_d = S_DONE;
            default: ctl_d = 4'b1000;
          endcase
        end
        S_REQUEST: begin
          state_d = S_WAIT;
`ifdef SIMD_WAIT_TIMEOUT_EN
          to_cnt_d = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (!mem_op || lanes_ready) begin
            state_d = S_EXECUTE;
          end
`ifdef SIMD_WAIT_TIMEOUT_EN
          else if (to_cnt_q == '0) begin
            state_d        = S_DONE;
            ctl_d          = 4'b0000;
            wait_timeout_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q - 1'b1;
          end
`endif
        end
        S_EXECUTE: state_d = S_UPDATE;
        S_UPDATE: begin
          if (!last_cycle) begin
            cycle_d = cycle_q + 1'b1;
            state_d = S_REQUEST;
          end else begin
            cycle_d      = '0;
            pc_advance_d = 1'b1;
            ctl_d        = 4'b0000;
            state_d      = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.simd_state      = state_q;
  assign bus.curr_wave_cycle = cycle_q;
  assign bus.lane_active     = lane_act;
  assign bus.REG_WRITE       = ctl_q[3];
  assign bus.MEM_READ        = ctl_q[2];
  assign bus.MEM_WRITE       = ctl_q[1];
  assign bus.MEM_TO_REG      = ctl_q[0];
  assign bus.pc_advance      = pc_advance_q;
  assign bus.simd_done       = simd_done_q;
`ifdef SIMD_WAIT_TIMEOUT_EN
  assign bus.wait_timeout    = wait_timeout_q;
`else
  assign bus.wait_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_simd_controller.sv
// Directed plus randomized bench for simd_controller against a lane-mask/latency reference model.
module tb_simd_controller;
  localparam int IW = 32;
  localparam int LW = 16;
  localparam int WS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int unsigned bdim, nthr, bid, wid;
  int          dly [2][16];

  simd_controller_if #(.INSTRUCTION_WIDTH(IW), .LANE_WIDTH(LW), .WAVE_SIZE(WS)) bus ();

  simd_controller #(
    .INSTRUCTION_WIDTH(IW), .LANE_WIDTH(LW), .WAVE_SIZE(WS)
`ifdef SIMD_WAIT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.REG_WRITE, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_TO_REG};
  endfunction

  // Opcode table: {REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG}
  function automatic logic [3:0] model_ctl(input logic [3:0] op);
    case (op)
      4'b0000: return 4'b0000;
      4'b1000: return 4'b1101;
      4'b1001: return 4'b0010;
      4'b1111: return 4'b0000;
      default: return 4'b1000;
    endcase
  endfunction

  // Valid threads of this block form the local range [0, min(block_dim, threads left)).
  function automatic logic [15:0] model_mask(input int c);
    longint base, lim, loc;
    logic [15:0] m;
    base = longint'(bid) * longint'(bdim);
    lim  = longint'(bdim);
    if (longint'(nthr) - base < lim) lim = longint'(nthr) - base;
    m = '0;
    for (int i = 0; i < LW; i++) begin
      loc  = longint'(wid) * WS + longint'(c) * LW + i;
      m[i] = (loc < lim);
    end
    return m;
  endfunction

  task automatic setup(input int unsigned d, input int unsigned n, input int unsigned b, input int unsigned w);
    bdim = d; nthr = n; bid = b; wid = w;
    bus.block_dim = d; bus.num_threads = n; bus.block_id = b; bus.wave_id = w;
  endtask

  task automatic start_wave();
    bus.simd_start = 1'b1;
    tick();
    bus.simd_start = 1'b0;
    chk("start_state", 32'(bus.simd_state), 32'd1);
    chk("start_done", 32'(bus.simd_done), 32'd0);
    chk("start_cycle", 32'(bus.curr_wave_cycle), 32'd0);
    chk("start_timeout", 32'(bus.wait_timeout), 32'd0);
  endtask

  task automatic run_instr(input logic [3:0] op, input bit noise);
    logic [3:0]  es;
    logic [15:0] m;
    int waits, exp_waits, elapsed, extra, maxd;
    bit mem;
    es  = model_ctl(op);
    mem = (op == 4'b1000) || (op == 4'b1001);
    bus.instr_valid = 1'b0;
    bus.simd_start  = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("fetch_hold", 32'(bus.simd_state), 32'd1);
      chk("fetch_pc", 32'(bus.pc_advance), 32'd0);
    end
    bus.instruction = {op, 28'($urandom)};
    bus.instr_valid = 1'b1;
    tick();
    chk("decode", 32'(bus.simd_state), 32'd2);
    elapsed = 0;
    extra   = 0;
    bus.instr_valid = 1'b0;
    bus.instruction = $urandom;
    if (op == 4'b1111) begin
      bus.simd_start = 1'b0;
      tick();
      chk("ret_state", 32'(bus.simd_state), 32'd7);
      chk("ret_strobes", 32'(strobes()), 32'd0);
      tick();
      chk("ret_done", 32'(bus.simd_done), 32'd1);
      return;
    end
    for (int c = 0; c < 2; c++) begin
      tick(); elapsed++;
      m = model_mask(c);
      chk("req_state", 32'(bus.simd_state), 32'd3);
      chk("req_cycle", 32'(bus.curr_wave_cycle), 32'(c));
      chk("req_mask", 32'(bus.lane_active), 32'(m));
      chk("req_strobes", 32'(strobes()), 32'(es));
      chk("req_pc", 32'(bus.pc_advance), 32'd0);
      maxd = 0;
      for (int i = 0; i < LW; i++) if (m[i] && dly[c][i] > maxd) maxd = dly[c][i];
      exp_waits = mem ? maxd + 1 : 1;
      tick(); elapsed++;
      chk("wait_state", 32'(bus.simd_state), 32'd4);
      waits = 0;
      while (bus.simd_state == 3'd4 && waits < 20) begin
        chk("wait_strobes", 32'(strobes()), 32'(es));
        for (int i = 0; i < LW; i++)
          bus.lsu_done[i] = m[i] ? (waits >= dly[c][i]) : (noise ? 1'($urandom) : 1'b0);
        bus.simd_start = 1'($urandom_range(0, 1));
        tick(); elapsed++; waits++;
      end
      chk("wait_len", 32'(waits), 32'(exp_waits));
      chk("exec_state", 32'(bus.simd_state), 32'd5);
      extra += waits - 1;
      tick(); elapsed++;
      chk("update_state", 32'(bus.simd_state), 32'd6);
    end
    tick(); elapsed++;
    chk("ret_fetch", 32'(bus.simd_state), 32'd1);
    chk("pc_pulse", 32'(bus.pc_advance), 32'd1);
    chk("pc_strobes", 32'(strobes()), 32'd0);
    chk("pc_cycle", 32'(bus.curr_wave_cycle), 32'd0);
    chk("latency", 32'(elapsed), 32'(9 + extra));
    bus.simd_start = 1'b0;
  endtask

  function automatic logic [3:0] rand_op();
    int p;
    logic [3:0] o;
    p = $urandom_range(0, 6);
    case (p)
      0: return 4'b0000;
      1, 2: return 4'b1000;
      3: return 4'b1001;
      4: return 4'b1111;
      default: begin
        o = 4'($urandom_range(1, 14));
        if (o == 4'b1000 || o == 4'b1001) o = 4'b0011;
        return o;
      end
    endcase
  endfunction

  task automatic clear_dly();
    for (int c = 0; c < 2; c++) for (int i = 0; i < LW; i++) dly[c][i] = 0;
  endtask

  initial begin
    int waits;
    logic [3:0] op;
    bus.enable = 1'b1; bus.simd_start = 1'b0; bus.instr_valid = 1'b0;
    bus.instruction = '0; bus.lsu_done = '0;
    setup(0, 0, 0, 0);
    clear_dly();

    tick(); tick();
    chk("rst_state", 32'(bus.simd_state), 32'd0);
    chk("rst_outs", 32'({strobes(), bus.pc_advance, bus.simd_done, bus.wait_timeout}), 32'd0);
    chk("rst_cycle", 32'(bus.curr_wave_cycle), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_hold", 32'(bus.simd_state), 32'd0);

    // ALU op, full wave
    setup(32, 64, 0, 0);
    start_wave();
    run_instr(4'b0001, 1'b1);

    // LDR with lane 5 three cycles late
    clear_dly();
    dly[0][5] = 3; dly[1][5] = 3;
    run_instr(4'b1000, 1'b1);

    // Partial block: cycle 1 has only lanes 3:0
    setup(20, 64, 0, 0);
    clear_dly();
    dly[1][2] = 2;
    run_instr(4'b1000, 1'b0);

    // RET, done held, restart
    run_instr(4'b1111, 1'b0);
    repeat (3) begin
      tick();
      chk("done_held", 32'(bus.simd_done), 32'd1);
      chk("done_state", 32'(bus.simd_state), 32'd7);
    end
    start_wave();

    for (int n = 0; n < 40; n++) begin
      setup($urandom_range(1, 48), $urandom_range(0, 160), $urandom_range(0, 3), $urandom_range(0, 1));
      for (int c = 0; c < 2; c++) for (int i = 0; i < LW; i++) dly[c][i] = $urandom_range(0, 5);
      op = rand_op();
      run_instr(op, 1'b1);
      if (op == 4'b1111) start_wave();
    end

    // enable freeze in REQUEST, then async reset mid-WAIT
    setup(32, 64, 0, 0);
    bus.lsu_done = '0;
    bus.instruction = {4'b1000, 28'h0};
    bus.instr_valid = 1'b1;
    tick();
    chk("frz_decode", 32'(bus.simd_state), 32'd2);
    bus.instr_valid = 1'b0;
    tick();
    chk("frz_req", 32'(bus.simd_state), 32'd3);
    bus.enable = 1'b0;
    bus.simd_start = 1'b1;
    repeat (5) begin
      tick();
      chk("frz_state", 32'(bus.simd_state), 32'd3);
      chk("frz_strobes", 32'(strobes()), 32'b1101);
    end
    bus.enable = 1'b1;
    bus.simd_start = 1'b0;
    tick();
    chk("frz_wait", 32'(bus.simd_state), 32'd4);
    repeat (3) begin
      tick();
      chk("wait_stuck", 32'(bus.simd_state), 32'd4);
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(bus.simd_state), 32'd0);
    chk("arst_outs", 32'({strobes(), bus.pc_advance, bus.simd_done, bus.wait_timeout}), 32'd0);
    chk("arst_cycle", 32'(bus.curr_wave_cycle), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst_idle", 32'(bus.simd_state), 32'd0);
    start_wave();

    // STR that never completes
    bus.lsu_done = '0;
    bus.instruction = {4'b1001, 28'h0};
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    chk("to_wait", 32'(bus.simd_state), 32'd4);
    waits = 0;
    while (bus.simd_state == 3'd4 && waits < 30) begin
      tick();
      waits++;
    end
`ifdef SIMD_WAIT_TIMEOUT_EN
    chk("to_len", 32'(waits), 32'd8);
    chk("to_state", 32'(bus.simd_state), 32'd7);
    chk("to_flag", 32'(bus.wait_timeout), 32'd1);
    tick();
    chk("to_done", 32'(bus.simd_done), 32'd1);
    chk("to_flag_held", 32'(bus.wait_timeout), 32'd1);
    start_wave();
`else
    chk("to_len", 32'(waits), 32'd30);
    chk("to_state", 32'(bus.simd_state), 32'd4);
    chk("to_flag", 32'(bus.wait_timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
